// File: rtl/keypad_scan4x4.sv
// Scanned 4x4 matrix-keypad reader: column strobe, row sync, debounce, key code out.
// Define KEYPAD_REPEAT_EN to add auto-repeat of key_valid while a key is held.
module keypad_scan4x4 #(
    parameter int unsigned SCAN_MAX       = 26999,
    parameter int unsigned DEBOUNCE_SCANS = 20
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
`endif
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam int unsigned CW = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;
    state_t state, state_next;

    logic [3:0]    row_meta, rs;
    logic [CW-1:0] tcnt;
    logic          tick;
    logic [1:0]    col_idx, col_idx_next, row_idx, row_idx_next, row_win;
    logic [7:0]    cnt, cnt_next;
    logic [3:0]    key_next;
    logic          key_valid_next, key_held_next;
    logic          any_low, same_low, cap_high, deb_done, rep_pulse;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_meta <= '1;
            rs       <= '1;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    assign tick = (tcnt == CW'(SCAN_MAX));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)     tcnt <= '0;
        else if (tick) tcnt <= '0;
        else           tcnt <= tcnt + 1'b1;
    end

    // Lowest-numbered low row wins when several rows are pressed together.
    always_comb begin
        row_win = 2'd0;
        if      (!rs[0]) row_win = 2'd0;
        else if (!rs[1]) row_win = 2'd1;
        else if (!rs[2]) row_win = 2'd2;
        else if (!rs[3]) row_win = 2'd3;
    end

    assign any_low  = (rs != 4'hF);
    assign same_low = any_low && (row_win == row_idx);
    assign cap_high = rs[row_idx];
    assign deb_done = ((cnt + 8'd1) == 8'(DEBOUNCE_SCANS));
    assign col      = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_SCAN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                S_SCAN:     if (any_low) state_next = S_DEBOUNCE;
                S_DEBOUNCE: if (!same_low) state_next = S_SCAN;
                            else if (deb_done) state_next = S_PRESSED;
                S_PRESSED:  if (cap_high) state_next = S_RELEASE;
                S_RELEASE:  if (!cap_high) state_next = S_PRESSED;
                            else if (deb_done) state_next = S_SCAN;
                default:    state_next = S_SCAN;
            endcase
        end
    end

    always_comb begin
        col_idx_next   = col_idx;
        row_idx_next   = row_idx;
        cnt_next       = cnt;
        key_next       = key;
        key_valid_next = rep_pulse;
        key_held_next  = key_held;
        if (tick) begin
            case (state)
                S_SCAN: begin
                    if (!any_low) begin
                        col_idx_next = col_idx + 2'd1;
                    end else begin
                        row_idx_next = row_win;
                        cnt_next     = 8'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!same_low) begin
                        col_idx_next = col_idx + 2'd1;
                    end else begin
                        cnt_next = cnt + 8'd1;
                        if (deb_done) begin
                            key_next       = {row_idx, col_idx};
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                        end
                    end
                end
                S_PRESSED: begin
                    if (cap_high) cnt_next = 8'd1;
                end
                S_RELEASE: begin
                    if (cap_high) begin
                        cnt_next = cnt + 8'd1;
                        if (deb_done) begin
                            key_held_next = 1'b0;
                            col_idx_next  = col_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            col_idx   <= '0;
            row_idx   <= '0;
            cnt       <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            col_idx   <= col_idx_next;
            row_idx   <= row_idx_next;
            cnt       <= cnt_next;
            key       <= key_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rcnt;
    logic        rep_phase;
    logic        rep_hit;

    assign rep_hit   = ((rcnt + 16'd1) == (rep_phase ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY)));
    assign rep_pulse = (state == S_PRESSED) && tick && !cap_high && rep_hit;

    // Holding the counter clear outside PRESSED restarts it on every entry, including from RELEASE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (state != S_PRESSED) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (tick && !cap_high) begin
            if (rep_hit) begin
                rcnt      <= '0;
                rep_phase <= 1'b1;
            end else begin
                rcnt <= rcnt + 16'd1;
            end
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif
endmodule

// File: doc/keypad_scan4x4.md
# keypad_scan4x4

Scanned 4x4 matrix-keypad reader: the input-side counterpart of the multiplexed 7-segment digit driver. The 7-segment driver strobes digits outward. This block strobes keypad columns, samples the rows, debounces, and returns one 4-bit key code per press. It sits between the board keypad pins and operand registers (e.g. adder inputs `a`/`b`), and runs on the system clock with its own scan-tick divider.

## Interface
- `SCAN_MAX`, 26999: scan tick every `SCAN_MAX+1` clocks (1 kHz at 27 MHz); counter width `$clog2(SCAN_MAX+1)`.
- `DEBOUNCE_SCANS`, 20: consecutive agreeing ticks required for press and for release; legal range 2..255.
- `REPEAT_DELAY`, 500: ticks held before the first auto-repeat (only with the macro).
- `REPEAT_RATE`, 100: ticks between later auto-repeats (only with the macro).
- `clk` in 1: system clock.
- `nrst` in 1: asynchronous active-low reset.
- `row` in 4: keypad rows, active-low, external pull-ups, asynchronous to `clk`.
- `col` out 4: column drive, active-low, exactly one bit low at all times.
- `key` out 4: last accepted key code, `row_idx*4 + col_idx`.
- `key_valid` out 1: one-clock pulse when `key` is updated.
- `key_held` out 1: high while the accepted key is considered down.

## Operation
- `row` passes through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- The tick counter counts 0..`SCAN_MAX` and wraps. `tick` is asserted in the cycle the count equals `SCAN_MAX`. All FSM decisions occur only on `tick`.
- `col_idx` (0..3) selects the column: `col = ~(4'b1 << col_idx)`.
- Row priority: if several rows are low, the lowest row index wins. The "same key" check compares the winning row index.
- FSM states:
  - SCAN:
    - If `rs` == 4'hF, advance `col_idx` (3 wraps to 0).
    - Else capture `row_idx`, set `cnt`=1, and go to DEBOUNCE. The column is held.
  - DEBOUNCE:
    - If the same row is still low, `cnt`++.
    - When `cnt` reaches `DEBOUNCE_SCANS`, load `key`, pulse `key_valid`, set `key_held`=1, and go to PRESSED.
    - If the row changes or releases, return to SCAN and advance `col_idx`. No output is produced.
  - PRESSED:
    - If the captured row is high, set `cnt`=1 and go to RELEASE.
    - Otherwise stay.
  - RELEASE:
    - If the captured row is low again, return to PRESSED.
    - If it stays high for `DEBOUNCE_SCANS` ticks, clear `key_held`, advance `col_idx`, and go to SCAN.
- The column never changes while in DEBOUNCE, PRESSED, or RELEASE.
- A second key pressed in another column while one key is held is ignored.

## Timing
- Reset values:
  - `col` = 4'b1110
  - `key` = 4'h0
  - `key_valid` = 0
  - `key_held` = 0
  - state SCAN, all counters 0
- Reset mid-operation returns everything to these values immediately. No `key_valid` is emitted and no stale key is kept.
- Outputs are registered. `key`, `key_valid` and `key_held` change in the clock after the deciding tick.
- Column settle time is one full tick period, because `rs` is sampled at the end of the tick interval in which the column was driven.
- Press latency after the column is first driven low on that key: `DEBOUNCE_SCANS` ticks plus 1 clock, plus a 2-clock synchronizer skew.
- `key_valid` is never high for two consecutive clocks.
- Counter wrap: the tick counter wraps to 0 on the same cycle `tick` fires.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In PRESSED, a repeat counter counts ticks.
  - After `REPEAT_DELAY` ticks, `key_valid` re-pulses with the unchanged `key`.
  - After that it re-pulses every `REPEAT_RATE` ticks.
  - The counter clears on entry to PRESSED, including re-entry from RELEASE.
- `KEYPAD_REPEAT_EN` undefined: exactly one `key_valid` per press, and no repeat logic is synthesized.

## Test plan
All scenarios use `SCAN_MAX`=3 (one tick per 4 clocks) and `DEBOUNCE_SCANS`=3.
- Reset, then idle with `row`=4'hF for 40 clocks:
  - `col` steps 1110, 1101, 1011, 0111, 1110, changing every 4 clocks.
  - `key_valid` stays 0.
- Key at row 2, col 1 held steady:
  - `row` reads 4'b1011 only while `col`=1101.
  - `key_valid` pulses once with `key`=4'h9.
  - `key_held`=1, and `col` freezes at 1101.
- Bounce: the same key is low for 2 ticks, then high:
  - No `key_valid`.
  - Scanning resumes at `col`=1011.
- Release:
  - Release glitches for 1 tick: `key_held` stays 1.
  - Release held for 3 ticks: `key_held` falls and scanning resumes.
- Rows 1 and 3 low together on col 0: `key`=4'h4.
- `nrst` pulsed low while in PRESSED:
  - `col`=1110, `key`=0, `key_held`=0 asynchronously.
- With `KEYPAD_REPEAT_EN`, `REPEAT_DELAY`=5 and `REPEAT_RATE`=2, key held:
  - `key_valid` pulses at press, then 5 ticks later, then every 2 ticks, all with the same `key`.
